// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle MIPS control slice.
// State enum, ALU op codes, opcode/funct values and datapath select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXE_R,
    S_WB_R,
    S_EXE_I,
    S_WB_I,
    S_MEM_ADR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BEQ
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// mc_alu_dec: R-type funct decoder.
// funct_i -> alu_op_o, legal_o (supported ALU funct), is_jr_o.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       legal_o,
  output logic       is_jr_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    legal_o  = 1'b1;
    is_jr_o  = 1'b0;
    unique case (funct_i)
      F_ADDU: alu_op_o = ALU_ADD;
      F_SUBU: alu_op_o = ALU_SUB;
      F_AND:  alu_op_o = ALU_AND;
      F_OR:   alu_op_o = ALU_OR;
      F_JR: begin
        legal_o = 1'b0;
        is_jr_o = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with mem_rdy stall and timeout.
// In: clk, reset_n, opcode, funct, zero, mem_rdy. Out: datapath selects/strobes.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic       bus_err,
  output logic       instr_done
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0] r_op;
  logic       r_legal;
  logic       r_jr;

  mc_alu_dec u_dec (
    .funct_i  (funct),
    .alu_op_o (r_op),
    .legal_o  (r_legal),
    .is_jr_o  (r_jr)
  );

  logic is_r;
  logic wait_st;
  logic tmo;

  assign is_r    = (opcode == OP_RTYPE);
  assign wait_st = (state_q == S_FETCH) ||
                   (state_q == S_MEM_RD) ||
                   (state_q == S_MEM_WR);
  // Ready in the same cycle always wins over the timeout.
  assign tmo     = (TIMEOUT != 0) && wait_st && !mem_rdy &&
                   (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = M2R_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    ext_op     = EXT_ZERO;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    instr_done = 1'b0;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_4;
        if (mem_rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo) begin
          bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        // Branch target is computed here into ALUOut.
        alu_src_b = SRCB_IMM2;
        ext_op    = EXT_SIGN;
        state_d   = S_FETCH;
        unique case (1'b1)
          opcode == OP_J: begin
            pc_write   = 1'b1;
            pc_src     = PC_JUMP;
            instr_done = 1'b1;
          end
          opcode == OP_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PC_JUMP;
            reg_write  = 1'b1;
            reg_dst    = RD_RA;
            mem_to_reg = M2R_PC;
            instr_done = 1'b1;
          end
          is_r && r_jr: begin
            pc_write   = 1'b1;
            pc_src     = PC_RS;
            instr_done = 1'b1;
          end
          is_r && r_legal: state_d = S_EXE_R;
          opcode == OP_ORI,
          opcode == OP_LUI: state_d = S_EXE_I;
          opcode == OP_LW,
          opcode == OP_SW: state_d = S_MEM_ADR;
          opcode == OP_BEQ: state_d = S_BEQ;
          default: illegal = 1'b1;
        endcase
      end
      S_EXE_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_op;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = RD_RD;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXE_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OR;
        ext_op    = (opcode == OP_LUI) ? EXT_LUI : EXT_ZERO;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = EXT_SIGN;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          state_d = S_WB_MEM;
        end else if (tmo) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (mem_rdy) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (tmo) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PC_ALUOUT;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

  // A timeout re-enters FETCH from FETCH, so it must clear explicitly.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || tmo || (TIMEOUT == 0)) begin
      cnt_d = '0;
    end else if (wait_st && !mem_rdy) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: per-instruction expected-trace model checked every cycle.
// Directed instruction list with latency pins and an async-reset probe.
module tb_mc_ctrl;

  localparam int TO = 4;

  localparam int K_R   = 0;
  localparam int K_JR  = 1;
  localparam int K_ORI = 2;
  localparam int K_LUI = 3;
  localparam int K_LW  = 4;
  localparam int K_SW  = 5;
  localparam int K_BEQ = 6;
  localparam int K_J   = 7;
  localparam int K_JAL = 8;
  localparam int K_ILL = 9;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       illegal;
    logic       bus_err;
    logic       instr_done;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    out_t       exp;
    int         id;
  } rec_t;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_rdy;
  logic       mem_req;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] ext_op;
  logic [2:0] alu_op;
  logic       illegal;
  logic       bus_err;
  logic       instr_done;

  mc_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .instr_done (instr_done)
  );

  out_t dut_o;
  assign dut_o = {mem_req, mem_write, ir_write, pc_write, pc_src,
                  reg_write, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, ext_op, alu_op, illegal, bus_err,
                  instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;
  bit   chk_en = 1'b0;
  rec_t cur;
  rec_t q[$];

  logic [5:0] b_op;
  logic [5:0] b_fn;
  logic       b_z;
  int         b_id = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] op,
                                  input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) return K_JR;
        if (fn inside {6'b100001, 6'b100011, 6'b100100, 6'b100101})
          return K_R;
        return K_ILL;
      end
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] rop(input logic [5:0] fn);
    case (fn)
      6'b100011: return 3'b001;
      6'b100100: return 3'b010;
      6'b100101: return 3'b011;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input out_t e, input logic rdy);
    rec_t r;
    r.op  = b_op;
    r.fn  = b_fn;
    r.z   = b_z;
    r.rdy = rdy;
    r.exp = e;
    r.id  = b_id;
    q.push_back(r);
  endtask

  // Memory wait phase: returns 0 when the access times out.
  task automatic mem_wait(input out_t w, input int mw, output bit ok);
    out_t e;
    if (mw > TO) begin
      repeat (TO) push(w, 1'b0);
      e = w;
      e.bus_err = 1'b1;
      push(e, 1'b0);
      ok = 1'b0;
    end else begin
      repeat (mw) push(w, 1'b0);
      ok = 1'b1;
    end
  endtask

  task automatic gen(input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int fw, input int mw);
    out_t f, e, w;
    int   k;
    bit   ok;
    b_op = op;
    b_fn = fn;
    b_z  = z;
    b_id++;
    f = '0;
    f.mem_req   = 1'b1;
    f.alu_src_b = 2'b01;
    if (fw > TO) begin
      repeat (TO) push(f, 1'b0);
      e = f;
      e.bus_err = 1'b1;
      push(e, 1'b0);
      fw = 0;
    end
    repeat (fw) push(f, 1'b0);
    e = f;
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    push(e, 1'b1);
    k = classify(op, fn);
    e = '0;
    e.alu_src_b = 2'b11;
    e.ext_op    = 2'b01;
    case (k)
      K_J, K_JAL, K_JR: begin
        e.pc_write   = 1'b1;
        e.pc_src     = (k == K_JR) ? 2'b11 : 2'b10;
        e.instr_done = 1'b1;
        if (k == K_JAL) begin
          e.reg_write  = 1'b1;
          e.reg_dst    = 2'b10;
          e.mem_to_reg = 2'b10;
        end
        push(e, rnd());
        return;
      end
      K_ILL: begin
        e.illegal = 1'b1;
        push(e, rnd());
        return;
      end
      default: push(e, rnd());
    endcase
    e = '0;
    e.alu_src_a = 1'b1;
    case (k)
      K_R: begin
        e.alu_op = rop(fn);
        push(e, rnd());
        e = '0;
        e.reg_write  = 1'b1;
        e.reg_dst    = 2'b01;
        e.instr_done = 1'b1;
        push(e, rnd());
      end
      K_ORI, K_LUI: begin
        e.alu_src_b = 2'b10;
        e.alu_op    = 3'b011;
        e.ext_op    = (k == K_LUI) ? 2'b10 : 2'b00;
        push(e, rnd());
        e = '0;
        e.reg_write  = 1'b1;
        e.instr_done = 1'b1;
        push(e, rnd());
      end
      K_LW, K_SW: begin
        e.alu_src_b = 2'b10;
        e.ext_op    = 2'b01;
        push(e, rnd());
        w = '0;
        w.mem_req   = 1'b1;
        w.mem_write = (k == K_SW);
        mem_wait(w, mw, ok);
        if (ok) begin
          e = w;
          e.instr_done = (k == K_SW);
          push(e, 1'b1);
          if (k == K_LW) begin
            e = '0;
            e.reg_write  = 1'b1;
            e.mem_to_reg = 2'b01;
            e.instr_done = 1'b1;
            push(e, rnd());
          end
        end
      end
      default: begin
        e.alu_op     = 3'b001;
        e.pc_src     = 2'b01;
        e.pc_write   = z;
        e.instr_done = 1'b1;
        push(e, rnd());
      end
    endcase
  endtask

  task automatic pin(input string nm, input logic [5:0] op,
                     input logic [5:0] fn, input logic z,
                     input int fw, input int mw, input int lat);
    int n0;
    n0 = q.size();
    gen(op, fn, z, fw, mw);
    chk(nm, 32'(q.size() - n0), 32'(lat));
  endtask

  task automatic run_q();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      opcode  = r.op;
      funct   = r.fn;
      zero    = r.z;
      mem_rdy = r.rdy;
      cur     = r;
      ncyc++;
      chk_en  = 1'b1;
    end
    @(negedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en)
      chk($sformatf("cyc%0d_ins%0d", ncyc, cur.id), 32'(dut_o),
          32'(cur.exp));
  end

  initial begin
    out_t jx;
    reset_n = 1'b0;
    opcode  = '0;
    funct   = '0;
    zero    = 1'b0;
    mem_rdy = 1'b0;

    pin("lat_addu",   6'b000000, 6'b100001, 1'b0, 0, 0, 4);
    pin("lat_subu_w", 6'b000000, 6'b100011, 1'b1, 1, 0, 5);
    pin("lat_and",    6'b000000, 6'b100100, 1'b0, 0, 0, 4);
    pin("lat_or",     6'b000000, 6'b100101, 1'b1, 0, 0, 4);
    pin("lat_ori",    6'b001101, 6'b010101, 1'b0, 0, 0, 4);
    pin("lat_lui",    6'b001111, 6'b000000, 1'b0, 0, 0, 4);
    pin("lat_lw_w3",  6'b100011, 6'b000000, 1'b0, 0, 3, 8);
    pin("lat_sw",     6'b101011, 6'b000000, 1'b0, 0, 0, 4);
    pin("lat_beq_z1", 6'b000100, 6'b000000, 1'b1, 0, 0, 3);
    pin("lat_beq_z0", 6'b000100, 6'b000000, 1'b0, 0, 0, 3);
    pin("lat_j",      6'b000010, 6'b000000, 1'b0, 0, 0, 2);
    pin("lat_jal",    6'b000011, 6'b000000, 1'b0, 0, 0, 2);
    jx = q[q.size() - 1].exp;
    chk("pin_jal_pcsrc", 32'(jx.pc_src), 32'd2);
    chk("pin_jal_regdst", 32'(jx.reg_dst), 32'd2);
    chk("pin_jal_m2r", 32'(jx.mem_to_reg), 32'd2);
    pin("lat_jr",     6'b000000, 6'b001000, 1'b0, 0, 0, 2);
    pin("lat_ill_op", 6'b111111, 6'b000000, 1'b0, 0, 0, 2);
    pin("lat_ill_fn", 6'b000000, 6'b000000, 1'b0, 0, 0, 2);
    pin("lat_f_tmo",  6'b000000, 6'b100001, 1'b0, 5, 0, 9);
    pin("lat_lw_edge", 6'b100011, 6'b000000, 1'b0, 4, 4, 13);
    pin("lat_sw_tmo", 6'b101011, 6'b000000, 1'b0, 0, 5, 8);
    pin("lat_lw_tmo", 6'b100011, 6'b000000, 1'b0, 0, 6, 8);
    pin("lat_ori_end", 6'b001101, 6'b000000, 1'b1, 2, 0, 6);

    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(dut_o), 32'd0);
    reset_n = 1'b1;
    run_q();

    b_op = 6'b101011;
    b_fn = 6'b000000;
    b_z  = 1'b0;
    b_id++;
    jx = '0;
    jx.mem_req   = 1'b1;
    jx.alu_src_b = 2'b01;
    jx.ir_write  = 1'b1;
    jx.pc_write  = 1'b1;
    push(jx, 1'b1);
    jx = '0;
    jx.alu_src_b = 2'b11;
    jx.ext_op    = 2'b01;
    push(jx, 1'b1);
    jx = '0;
    jx.alu_src_a = 1'b1;
    jx.alu_src_b = 2'b10;
    jx.ext_op    = 2'b01;
    push(jx, 1'b1);
    jx = '0;
    jx.mem_req   = 1'b1;
    jx.mem_write = 1'b1;
    push(jx, 1'b0);
    push(jx, 1'b0);
    run_q();

    chk("pre_rst_mem_write", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_all_zero", 32'(dut_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_release_zero", 32'(dut_o), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_fetch", 32'(mem_req), 32'd1);
    chk("post_rst_no_irw", 32'(ir_write), 32'd0);
    chk("post_rst_no_wr", 32'(mem_write), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle MIPS control FSM: the producer side of the ALU op interface. It decodes the held instruction, drives the 3-bit ALU op code and the datapath select and strobe signals, and sequences fetch, decode, execute, memory and writeback. It stalls on a memory ready handshake and flags illegal instructions and memory timeouts. It sits between the instruction register and memory port on one side and the ALU, register file and PC on the other.

Parameters:
TIMEOUT, 255, maximum cycles to wait for mem_rdy in any memory state; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU result equals 0
mem_rdy  in  1  memory completes this cycle
mem_req  out  1  memory access request
mem_write  out  1  store strobe, valid while mem_req is high
ir_write  out  1  load the IR
pc_write  out  1  load the PC
pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target, 11 rs
reg_write  out  1  register-file write strobe
reg_dst  out  2  00 rt, 01 rd, 10 register 31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 constant 4, 10 ext imm, 11 ext imm shifted left 2
ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm shifted left 16
alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra
illegal  out  1  1-cycle pulse on an unsupported opcode or funct
bus_err  out  1  1-cycle pulse on a memory timeout
instr_done  out  1  1-cycle pulse in each instruction's final state

Behaviour:
- Outputs are combinational from the state register plus opcode/funct. No output decodes from a non-state input except pc_write in BEQ (zero) and the mem_rdy-gated strobes.
- Asserting reset_n low forces RESET immediately and clears the timeout counter. In RESET all outputs are 0.
- After reset release, RESET goes to FETCH on the first clock.
- Any output not listed for a state is 0.
- Supported instructions: addu, subu, and, or (R-type); ori, lui, lw, sw, beq, j, jal, jr.
- R-type funct to alu_op: 100001 -> 000, 100011 -> 001, 100100 -> 010, 100101 -> 011.
- States and transitions:
  - FETCH: mem_req=1, alu_src_b=01, alu_op=000. Wait for mem_rdy. When mem_rdy=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
  - DECODE: alu_src_b=11, ext_op=01, alu_op=000 (branch target into ALUOut).
    - j: pc_write=1, pc_src=10, instr_done, go to FETCH.
    - jal: same as j, plus reg_write=1, reg_dst=10, mem_to_reg=10.
    - jr (R-type, funct 001000): pc_write=1, pc_src=11, instr_done, go to FETCH.
    - R-type go to EXE_R; ori/lui go to EXE_I; lw/sw go to MEM_ADR; beq goes to BEQ.
    - Anything else: illegal=1, go to FETCH.
  - EXE_R: alu_src_a=1, alu_src_b=00, alu_op from funct. Go to WB_R.
  - WB_R: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done. Go to FETCH.
  - EXE_I: alu_src_a=1, alu_src_b=10.
    - ori: ext_op=00, alu_op=011.
    - lui: ext_op=10, alu_op=011 (rs is $0 by encoding).
    - Go to WB_I.
  - WB_I: reg_write=1, reg_dst=00, mem_to_reg=00, instr_done. Go to FETCH.
  - MEM_ADR: alu_src_a=1, alu_src_b=10, ext_op=01, alu_op=000. lw goes to MEM_RD, sw goes to MEM_WR.
  - MEM_RD: mem_req=1. Wait for mem_rdy, then go to WB_MEM.
  - WB_MEM: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done. Go to FETCH.
  - MEM_WR: mem_req=1, mem_write=1. Wait for mem_rdy, then instr_done and go to FETCH.
  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_write=zero, instr_done. Go to FETCH.
- Zero-wait latency (mem_rdy already high): R-type/ori/lui 4 cycles; lw 5; sw 4; beq 3; j/jal/jr 2.
- Timeout counter:
  - Counts cycles spent in FETCH, MEM_RD or MEM_WR with mem_rdy=0; clears on any state change.
  - When the count reaches TIMEOUT with mem_rdy still 0: bus_err=1 for 1 cycle, then go to FETCH. No ir_write, pc_write or reg_write occurs.
  - mem_rdy=1 in the same cycle the count reaches TIMEOUT: the completion wins and no bus_err is raised.
- Asserting reset_n mid-instruction: the instruction is abandoned with no partial writes after the reset edge.

Decomposition:
- Shared package mc_pkg holds:
  - state enum;
  - ALU op constants (ALU_ADD=000 … ALU_SRA=101, shared with the ALU);
  - opcode/funct constants;
  - select-code constants for pc_src, reg_dst, mem_to_reg, alu_src_b and ext_op.
- One natural sub-module: mc_alu_dec, a combinational funct -> {alu_op, legal, is_jr} decoder.

Test Plan:
- addu (op 000000, funct 100001), mem_rdy tied 1 -> alu_op=000 in EXE_R; reg_write=1 with reg_dst=01 on cycle 4; instr_done on cycle 4.
- lw (op 100011) with mem_rdy low 3 cycles in MEM_RD -> mem_req held 4 cycles; WB_MEM asserts reg_write with mem_to_reg=01; total 8 cycles.
- beq (op 000100): zero=1 -> pc_write=1, pc_src=01 in cycle 3. zero=0 -> pc_write=0 in cycle 3.
- jal (op 000011) -> in DECODE: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10; next state FETCH.
- TIMEOUT=4, mem_rdy held 0 in FETCH -> bus_err pulses after 4 waiting cycles; ir_write stays 0; FETCH re-entered.
- Opcode 111111 -> illegal=1 for 1 cycle in DECODE; then FETCH. reset_n pulsed low during MEM_WR -> mem_write drops immediately; all outputs 0; FETCH one cycle after release.
